// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and flag-update-mask definitions for the ALU flag writeback stage.
package alu_pkg;

  localparam int FLAG_N = 6;

  localparam int CF = 5;
  localparam int ZF = 4;
  localparam int NF = 3;
  localparam int VF = 2;
  localparam int PF = 1;
  localparam int AF = 0;

  localparam logic [4:0] OP_INC = 5'b00001;
  localparam logic [4:0] OP_DEC = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_ADC = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SBB = 5'b00111;
  localparam logic [4:0] OP_AND = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01001;
  localparam logic [4:0] OP_XOR = 5'b01010;
  localparam logic [4:0] OP_NOT = 5'b01011;
  localparam logic [4:0] OP_SHL = 5'b10000;
  localparam logic [4:0] OP_SHR = 5'b10001;
  localparam logic [4:0] OP_SAL = 5'b10010;
  localparam logic [4:0] OP_SAR = 5'b10011;
  localparam logic [4:0] OP_ROL = 5'b10100;
  localparam logic [4:0] OP_ROR = 5'b10101;
  localparam logic [4:0] OP_RCL = 5'b10110;
  localparam logic [4:0] OP_RCR = 5'b10111;

  localparam logic [FLAG_N-1:0] ARITH_TAKE_MASK = 6'b111111;
  localparam logic [FLAG_N-1:0] LOGIC_TAKE_MASK = (6'd1 << ZF) | (6'd1 << NF) | (6'd1 << PF);
  localparam logic [FLAG_N-1:0] LOGIC_CLR_MASK  = (6'd1 << CF) | (6'd1 << VF);
  localparam logic [FLAG_N-1:0] SHIFT_TAKE_MASK = ~((6'd1 << VF) | (6'd1 << AF));

  typedef enum logic [1:0] {
    CLS_ARITH   = 2'd0,
    CLS_LOGIC   = 2'd1,
    CLS_SHIFT   = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] f);
    op_class_e cls;
    case (f)
      OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB: cls = CLS_ARITH;
      OP_AND, OP_OR, OP_XOR, OP_NOT:                  cls = CLS_LOGIC;
      OP_SHL, OP_SHR, OP_SAL, OP_SAR,
      OP_ROL, OP_ROR, OP_RCL, OP_RCR:                 cls = CLS_SHIFT;
      default:                                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic is_legal(input logic [4:0] f);
    return op_class(f) != CLS_ILLEGAL;
  endfunction

  // Bits taken from the ALU status; illegal opcodes take nothing so flags hold.
  function automatic logic [FLAG_N-1:0] upd_mask(input logic [4:0] f);
    logic [FLAG_N-1:0] m;
    case (op_class(f))
      CLS_ARITH: m = ARITH_TAKE_MASK;
      CLS_LOGIC: m = LOGIC_TAKE_MASK;
      CLS_SHIFT: m = SHIFT_TAKE_MASK;
      default:   m = 6'b000000;
    endcase
    return m;
  endfunction

  function automatic logic [FLAG_N-1:0] clr_mask(input logic [4:0] f);
    logic [FLAG_N-1:0] m;
    if (op_class(f) == CLS_LOGIC) begin
      m = LOGIC_CLR_MASK;
    end else begin
      m = 6'b000000;
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_flag_writeback_if.sv
// ALU-to-writeback handshake bundle: upstream ALU result port and downstream writeback port.
interface alu_flag_writeback_if #(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_f;
  logic [DATA_W-1:0] in_result;
  logic [FLAG_W-1:0] in_status;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [FLAG_W-1:0] out_flags;

  modport master (
    output in_valid, in_f, in_result, in_status, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_f, in_result, in_status, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/alu_wb_fifo.sv
// Two-entry valid/ready FIFO; the head is a dedicated register so the output holds its last value when empty.
module alu_wb_fifo #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         ready,
  output logic [1:0]   count
);

  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic [1:0]   cnt_r;
  logic         ready_r;
  logic         do_push_s;
  logic         do_pop_s;
  logic [1:0]   cnt_nxt_s;

  assign do_push_s = push && ready_r;
  assign do_pop_s  = pop && (cnt_r != 2'd0);

  // Next occupancy from the push/pop pair.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_nxt_s = cnt_r + 2'd1;
      2'b01:   cnt_nxt_s = cnt_r - 2'd1;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Entry storage, occupancy and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {W{1'b0}};
      tail_r  <= {W{1'b0}};
      cnt_r   <= 2'd0;
      ready_r <= 1'b1;
    end else begin
      cnt_r   <= cnt_nxt_s;
      ready_r <= (cnt_nxt_s != 2'd2);
      if (do_pop_s) begin
        if (cnt_r == 2'd2) begin
          head_r <= tail_r;
          if (do_push_s) begin
            tail_r <= din;
          end else begin
            tail_r <= tail_r;
          end
        end else if (do_push_s) begin
          head_r <= din;
        end else begin
          head_r <= head_r;
        end
      end else if (do_push_s) begin
        if (cnt_r == 2'd0) begin
          head_r <= din;
        end else begin
          tail_r <= din;
        end
      end else begin
        head_r <= head_r;
      end
    end
  end

  assign dout  = head_r;
  assign valid = (cnt_r != 2'd0);
  assign ready = ready_r;
  assign count = cnt_r;

endmodule

// File: rtl/alu_flag_writeback.sv
// ALU flag writeback: per-opcode flag merge, carry feedback, sticky illegal-op error, 2-entry output buffer.
// Optional ALU_FLAG_FORCE_EN adds a whole-register flag overwrite port.
module alu_flag_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FLAG_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_flag_writeback_if.slave bus,
  output logic [FLAG_W-1:0] flags,
  output logic              cin_out,
  output logic              err_illegal,
  output logic [1:0]        occupancy
`ifdef ALU_FLAG_FORCE_EN
  ,
  input  logic              flag_wr_en,
  input  logic [FLAG_W-1:0] flag_wr_data
`endif
);

  logic [FLAG_W-1:0]        flags_r;
  logic [FLAG_W-1:0]        new_flags_s;
  logic [FLAG_N-1:0]        take_s;
  logic [FLAG_N-1:0]        clr_s;
  logic                     accept_s;
  logic                     ready_s;
  logic                     err_r;
  logic [DATA_W+FLAG_W-1:0] fifo_dout_s;

  assign accept_s = bus.in_valid && ready_s;

  // Masked-off status bits are ANDed away, so x there never reaches the flags.
  always_comb begin
    take_s      = upd_mask(bus.in_f);
    clr_s       = clr_mask(bus.in_f);
    new_flags_s = ((flags_r & ~take_s) | (bus.in_status & take_s)) & ~clr_s;
  end

  // Architectural flag register and sticky illegal-opcode error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= {FLAG_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
`ifdef ALU_FLAG_FORCE_EN
      if (flag_wr_en) begin
        flags_r <= flag_wr_data;
      end else if (accept_s) begin
        flags_r <= new_flags_s;
      end else begin
        flags_r <= flags_r;
      end
`else
      if (accept_s) begin
        flags_r <= new_flags_s;
      end else begin
        flags_r <= flags_r;
      end
`endif
      if (accept_s && !is_legal(bus.in_f)) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  // The queued flags are the op-updated value, independent of any force.
  alu_wb_fifo #(
    .W(DATA_W + FLAG_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept_s),
    .pop   (bus.out_ready),
    .din   ({bus.in_result, new_flags_s}),
    .dout  (fifo_dout_s),
    .valid (bus.out_valid),
    .ready (ready_s),
    .count (occupancy)
  );

  assign bus.in_ready   = ready_s;
  assign bus.out_result = fifo_dout_s[DATA_W+FLAG_W-1:FLAG_W];
  assign bus.out_flags  = fifo_dout_s[FLAG_W-1:0];
  assign flags          = flags_r;
  assign cin_out        = flags_r[CF];
  assign err_illegal    = err_r;

endmodule

// File: tb/tb_alu_flag_writeback.sv
// Directed self-checking bench for alu_flag_writeback; expected flag values are hand-derived per opcode class.
module tb_alu_flag_writeback;
  import alu_pkg::*;

  localparam int DATA_W = 16;
  localparam int FLAG_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [FLAG_W-1:0] flags;
  logic              cin_out;
  logic              err_illegal;
  logic [1:0]        occupancy;
  logic [15:0]       adc_res;
  int                n_checks = 0;
  int                n_fail = 0;
`ifdef ALU_FLAG_FORCE_EN
  logic              flag_wr_en = 1'b0;
  logic [FLAG_W-1:0] flag_wr_data = 6'h00;
`endif

  always #5 clk = ~clk;

  alu_flag_writeback_if #(.DATA_W(DATA_W), .FLAG_W(FLAG_W)) bus ();

  alu_flag_writeback #(.DATA_W(DATA_W), .FLAG_W(FLAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flags       (flags),
    .cin_out     (cin_out),
    .err_illegal (err_illegal),
    .occupancy   (occupancy)
`ifdef ALU_FLAG_FORCE_EN
    ,
    .flag_wr_en  (flag_wr_en),
    .flag_wr_data(flag_wr_data)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] f, input logic [15:0] r, input logic [5:0] s);
    bus.in_valid  = v;
    bus.in_f      = f;
    bus.in_result = r;
    bus.in_status = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, OP_ADD, 16'h0000, 6'h00);
    #12;
    n_checks++; if ({bus.out_valid, bus.out_result, bus.out_flags} !== {1'b0, 16'h0000, 6'h00}) begin
      n_fail++; $display("FAIL reset_out: got v=%b r=%h f=%h want 0/0000/00", bus.out_valid, bus.out_result, bus.out_flags); end
    n_checks++; if ({flags, cin_out, err_illegal} !== {6'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_flags: got flags=%h cin=%b err=%b want 00/0/0", flags, cin_out, err_illegal); end
    n_checks++; if ({bus.in_ready, occupancy} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL reset_buf: got in_ready=%b occ=%0d want 1/0", bus.in_ready, occupancy); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    drive(1'b1, OP_ADD, 16'h0000, 6'h33);
    step();
    n_checks++; if ({bus.out_valid, bus.out_result, bus.out_flags} !== {1'b1, 16'h0000, 6'h33}) begin
      n_fail++; $display("FAIL add_out: got v=%b r=%h f=%h want 1/0000/33", bus.out_valid, bus.out_result, bus.out_flags); end
    n_checks++; if ({flags, cin_out, occupancy} !== {6'h33, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL add_flags: got flags=%h cin=%b occ=%0d want 33/1/1", flags, cin_out, occupancy); end
    adc_res = 16'h0001 + 16'h0001 + {15'd0, cin_out};
    drive(1'b1, OP_ADC, adc_res, 6'h02);
    step();
    n_checks++; if ({bus.out_valid, bus.out_result, bus.out_flags[CF]} !== {1'b1, 16'h0003, 1'b0}) begin
      n_fail++; $display("FAIL adc_out: got v=%b r=%h cf=%b want 1/0003/0", bus.out_valid, bus.out_result, bus.out_flags[CF]); end
    n_checks++; if ({flags, cin_out} !== {6'h02, 1'b0}) begin
      n_fail++; $display("FAIL adc_flags: got flags=%h cin=%b want 02/0", flags, cin_out); end
    drive(1'b0, OP_ADD, 16'h0000, 6'h00);
    step();
    n_checks++; if ({bus.out_valid, occupancy, bus.out_result} !== {1'b0, 2'd0, 16'h0003}) begin
      n_fail++; $display("FAIL empty_hold: got v=%b occ=%0d r=%h want 0/0/0003", bus.out_valid, occupancy, bus.out_result); end
  endtask

  task automatic test_logic();
    drive(1'b1, OP_ADD, 16'h0000, 6'h33);
    step();
    drive(1'b1, OP_AND, 16'h0F00, 6'bx00x1x);
    step();
    n_checks++; if ({bus.out_result, bus.out_flags, flags} !== {16'h0F00, 6'h03, 6'h03}) begin
      n_fail++; $display("FAIL and_flags: got r=%h of=%h flags=%h want 0F00/03/03", bus.out_result, bus.out_flags, flags); end
    drive(1'b0, OP_ADD, 16'h0000, 6'h00);
    step();
  endtask

  task automatic test_shift();
    drive(1'b1, OP_SUB, 16'h7FFF, 6'h07);
    step();
    n_checks++; if (flags !== 6'h07) begin
      n_fail++; $display("FAIL sub_flags: got %h want 07", flags); end
    drive(1'b1, OP_SHL, 16'h0000, 6'b110x1x);
    step();
    n_checks++; if ({bus.out_result, bus.out_flags, flags, cin_out} !== {16'h0000, 6'h37, 6'h37, 1'b1}) begin
      n_fail++; $display("FAIL shl_flags: got r=%h of=%h flags=%h cin=%b want 0000/37/37/1", bus.out_result, bus.out_flags, flags, cin_out); end
    drive(1'b0, OP_ADD, 16'h0000, 6'h00);
    step();
  endtask

  task automatic test_full();
    bus.out_ready = 1'b0;
    drive(1'b1, OP_INC, 16'h0011, 6'h00);
    step();
    n_checks++; if ({occupancy, bus.in_ready} !== {2'd1, 1'b1}) begin
      n_fail++; $display("FAIL fill_one: got occ=%0d rdy=%b want 1/1", occupancy, bus.in_ready); end
    drive(1'b1, OP_INC, 16'h0022, 6'h08);
    step();
    n_checks++; if ({occupancy, bus.in_ready, bus.out_result} !== {2'd2, 1'b0, 16'h0011}) begin
      n_fail++; $display("FAIL fill_two: got occ=%0d rdy=%b r=%h want 2/0/0011", occupancy, bus.in_ready, bus.out_result); end
    drive(1'b1, OP_INC, 16'h0033, 6'h21);
    step();
    step();
    n_checks++; if ({occupancy, bus.in_ready, bus.out_valid, bus.out_result, bus.out_flags, flags} !== {2'd2, 1'b0, 1'b1, 16'h0011, 6'h00, 6'h08}) begin
      n_fail++; $display("FAIL stall: got occ=%0d rdy=%b v=%b r=%h of=%h flags=%h want 2/0/1/0011/00/08",
                         occupancy, bus.in_ready, bus.out_valid, bus.out_result, bus.out_flags, flags); end
    bus.out_ready = 1'b1;
    step();
    n_checks++; if ({occupancy, bus.in_ready, bus.out_result, bus.out_flags, flags} !== {2'd1, 1'b1, 16'h0022, 6'h08, 6'h08}) begin
      n_fail++; $display("FAIL drain_first: got occ=%0d rdy=%b r=%h of=%h flags=%h want 1/1/0022/08/08",
                         occupancy, bus.in_ready, bus.out_result, bus.out_flags, flags); end
    step();
    n_checks++; if ({occupancy, bus.out_result, bus.out_flags, flags} !== {2'd1, 16'h0033, 6'h21, 6'h21}) begin
      n_fail++; $display("FAIL drain_third: got occ=%0d r=%h of=%h flags=%h want 1/0033/21/21", occupancy, bus.out_result, bus.out_flags, flags); end
    drive(1'b0, OP_ADD, 16'h0000, 6'h00);
    step();
    n_checks++; if ({occupancy, bus.out_valid, bus.out_result} !== {2'd0, 1'b0, 16'h0033}) begin
      n_fail++; $display("FAIL drain_empty: got occ=%0d v=%b r=%h want 0/0/0033", occupancy, bus.out_valid, bus.out_result); end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    drive(1'b1, 5'b11111, 16'hBEEF, 6'h1E);
    step();
    n_checks++; if ({bus.out_valid, bus.out_result, bus.out_flags, flags, err_illegal} !== {1'b1, 16'hBEEF, 6'h21, 6'h21, 1'b1}) begin
      n_fail++; $display("FAIL illegal_op: got v=%b r=%h of=%h flags=%h err=%b want 1/BEEF/21/21/1",
                         bus.out_valid, bus.out_result, bus.out_flags, flags, err_illegal); end
    drive(1'b1, 5'b00000, 16'h1111, 6'h3F);
    step();
    n_checks++; if ({flags, err_illegal} !== {6'h21, 1'b1}) begin
      n_fail++; $display("FAIL illegal_zero: got flags=%h err=%b want 21/1", flags, err_illegal); end
    drive(1'b1, OP_ADD, 16'h0000, 6'h33);
    step();
    n_checks++; if ({flags, err_illegal} !== {6'h33, 1'b1}) begin
      n_fail++; $display("FAIL illegal_sticky: got flags=%h err=%b want 33/1", flags, err_illegal); end
    drive(1'b0, OP_ADD, 16'h0000, 6'h00);
    step();
  endtask

  task automatic test_midstream_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 16'h1234, 6'h3F);
    step();
    drive(1'b1, OP_ADD, 16'h5678, 6'h01);
    step();
    n_checks++; if ({occupancy, flags} !== {2'd2, 6'h01}) begin
      n_fail++; $display("FAIL pre_reset: got occ=%0d flags=%h want 2/01", occupancy, flags); end
    drive(1'b0, OP_ADD, 16'h0000, 6'h00);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.out_valid, bus.out_result, bus.out_flags, flags, cin_out, err_illegal, occupancy, bus.in_ready} !==
                    {1'b0, 16'h0000, 6'h00, 6'h00, 1'b0, 1'b0, 2'd0, 1'b1}) begin
      n_fail++; $display("FAIL async_reset: got v=%b r=%h of=%h flags=%h cin=%b err=%b occ=%0d rdy=%b want 0/0000/00/00/0/0/0/1",
                         bus.out_valid, bus.out_result, bus.out_flags, flags, cin_out, err_illegal, occupancy, bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

`ifdef ALU_FLAG_FORCE_EN
  task automatic test_force();
    bus.out_ready = 1'b1;
    drive(1'b1, OP_ADD, 16'h0000, 6'h33);
    flag_wr_en   = 1'b1;
    flag_wr_data = 6'h3F;
    step();
    flag_wr_en = 1'b0;
    drive(1'b0, OP_ADD, 16'h0000, 6'h00);
    n_checks++; if ({flags, bus.out_flags} !== {6'h3F, 6'h33}) begin
      n_fail++; $display("FAIL force: got flags=%h of=%h want 3F/33", flags, bus.out_flags); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_logic();
    test_shift();
    test_full();
    test_illegal();
    test_midstream_reset();
`ifdef ALU_FLAG_FORCE_EN
    test_force();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
